// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage buffer.
//   MAX_LANES    : widest instruction group any stage boundary may carry
//   lane_ctrl_t  : per-lane control bundle (valid plus exception flag)
//   buf_state_t  : head/skid steering states (EMPTY, ONE, FULL)
//   kill_younger : masks the valid bits of lanes younger than an excepting lane
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int MAX_LANES = 4;

    typedef struct packed {
        logic valid;
        logic exc;
    } lane_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // Lane 0 is the oldest. The first valid lane that carries an exception
    // keeps its own valid bit, but every younger lane is squashed because it
    // must never execute past the faulting instruction.
    function automatic logic [MAX_LANES-1:0] kill_younger(
        input logic [MAX_LANES-1:0] valid,
        input logic [MAX_LANES-1:0] exc
    );
        logic [MAX_LANES-1:0] masked;
        logic                 killed;
        masked = '0;
        killed = 1'b0;
        for (int i = 0; i < MAX_LANES; i++) begin
            masked[i] = valid[i] & ~killed;
            if (valid[i] && exc[i]) begin
                killed = 1'b1;
            end
        end
        return masked;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One buffer entry: an instruction group payload plus its per-lane valids.
//   clk, rst  : stage clock, synchronous active-high reset
//   load      : capture d_valid/d_data on this edge
//   clear     : drop the entry (valids cleared, payload kept); beats load
//   d_valid   : per-lane valids to capture
//   d_data    : lane payloads to capture
//   q_valid   : held per-lane valids
//   q_data    : held lane payloads
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [LANES-1:0]       d_valid,
    input  logic [LANES*WIDTH-1:0] d_data,
    output logic [LANES-1:0]       q_valid,
    output logic [LANES*WIDTH-1:0] q_data
);

    // Payload is reset only to keep the output deterministic; clear leaves it
    // alone since consumers always qualify it with the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= '0;
            q_data  <= '0;
        end else if (clear) begin
            q_valid <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
// Pipeline stage register carrying an N-lane instruction group with a
// valid/ready handshake, optional skid entry, flush and exception kill.
//   clk, rst   : stage clock, synchronous active-high reset
//   in_valid   : per-lane valid from upstream (group present if any set)
//   in_data    : lane payloads, lane i at [i*WIDTH +: WIDTH]
//   in_ready   : group-level accept toward upstream
//   out_valid  : per-lane valid of the head group
//   out_data   : head group payloads
//   out_ready  : downstream accepts the head group
//   flush      : discard everything held and arriving this cycle
//   stall_cnt  : saturating count of cycles with a blocked valid head
//   occupancy  : groups currently held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int WIDTH   = 32,
    parameter int LANES   = 1,
    parameter int SKID    = 1,
    parameter int EXC_BIT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [1:0]             occupancy
);

    import pipe_pkg::*;

    lane_ctrl_t [MAX_LANES-1:0] in_ctrl;
    logic [MAX_LANES-1:0]       vld_pad;
    logic [MAX_LANES-1:0]       exc_pad;
    logic [LANES-1:0]           cap_valid;

    buf_state_t                 state;
    buf_state_t                 state_next;

    logic                       accept;
    logic                       retire;
    logic                       from_skid;

    logic                       head_load;
    logic                       head_clear;
    logic [LANES-1:0]           head_d_valid;
    logic [LANES*WIDTH-1:0]     head_d_data;
    logic [LANES-1:0]           head_valid;
    logic [LANES*WIDTH-1:0]     head_data;

    logic [LANES-1:0]           skid_valid;
    logic [LANES*WIDTH-1:0]     skid_data;

    // Gather each lane's valid and exception flag, padded out to the package
    // lane width so the shared kill function can be used for any LANES.
    always_comb begin
        in_ctrl = '0;
        vld_pad = '0;
        exc_pad = '0;
        for (int i = 0; i < LANES; i++) begin
            in_ctrl[i].valid = in_valid[i];
            in_ctrl[i].exc   = in_data[i*WIDTH + EXC_BIT];
        end
        for (int i = 0; i < MAX_LANES; i++) begin
            vld_pad[i] = in_ctrl[i].valid;
            exc_pad[i] = in_ctrl[i].exc;
        end
    end

    assign cap_valid = LANES'(kill_younger(vld_pad, exc_pad));

    assign accept    = (|in_valid) && in_ready;
    assign retire    = (|out_valid) && out_ready;
    assign out_valid = head_valid;
    assign out_data  = head_data;

    // The head refills from skid only when both entries are occupied;
    // otherwise any head load is a fresh group from upstream.
    assign from_skid    = (state == FULL);
    assign head_d_valid = from_skid ? skid_valid : cap_valid;
    assign head_d_data  = from_skid ? skid_data  : in_data;

    pipe_slot #(.WIDTH(WIDTH), .LANES(LANES)) u_head (
        .clk     (clk),
        .rst     (rst),
        .load    (head_load),
        .clear   (head_clear),
        .d_valid (head_d_valid),
        .d_data  (head_d_data),
        .q_valid (head_valid),
        .q_data  (head_data)
    );

    // With a skid entry, in_ready comes straight from the skid valid register
    // so upstream never sees a path from out_ready. Without it, the single
    // register may accept whenever it is empty or draining this cycle.
    generate
        if (SKID != 0) begin : g_skid
            logic skid_load;
            logic skid_clear;

            assign skid_load  = !flush && (state == ONE) && accept && !retire;
            assign skid_clear = flush || ((state == FULL) && retire);

            pipe_slot #(.WIDTH(WIDTH), .LANES(LANES)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (skid_clear),
                .d_valid (cap_valid),
                .d_data  (in_data),
                .q_valid (skid_valid),
                .q_data  (skid_data)
            );

            assign in_ready = !rst && !(|skid_valid);
        end else begin : g_noskid
            assign skid_valid = '0;
            assign skid_data  = '0;
            assign in_ready   = !rst && (!(|head_valid) || out_ready);
        end
    endgenerate

    // Steering state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Steering decisions. Flush wins over everything and drops both entries
    // plus any group accepted this cycle. In ONE, a simultaneous retire and
    // accept replaces the head in place; an accept alone spills into skid.
    always_comb begin
        state_next = state;
        head_load  = 1'b0;
        head_clear = 1'b0;
        if (flush) begin
            state_next = EMPTY;
            head_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (retire && accept) begin
                        head_load = 1'b1;
                    end else if (retire) begin
                        head_clear = 1'b1;
                        state_next = EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (retire) begin
                        head_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    head_clear = 1'b1;
                end
            endcase
        end
    end

    // Occupancy is a direct decode of the steering state.
    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Performance counter: one tick per cycle with a blocked valid head,
    // sticking at all-ones. Flush does not touch it; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((|out_valid) && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
// Directed bench for pipe_stage_buf. Instance A is a 2-lane skid buffer with
// a 4-bit stall counter; instance B is a 1-lane buffer without skid.
// Inputs change 1ns after the rising edge, outputs are sampled on the
// falling edge, so each table row lists the outputs seen in the cycle its
// inputs are applied.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    typedef struct {
        logic [1:0]  iv;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic [1:0]  ov;
        logic [15:0] od;
        logic        ir;
        logic [1:0]  occ;
        logic [7:0]  st;
    } vec_t;

    logic        clk;
    logic        rst;

    logic [1:0]  a_iv;
    logic [15:0] a_d;
    logic        a_ir;
    logic [1:0]  a_ov;
    logic [15:0] a_od;
    logic        a_ordy;
    logic        a_fl;
    logic [3:0]  a_st;
    logic [1:0]  a_occ;

    logic [0:0]  b_iv;
    logic [7:0]  b_d;
    logic        b_ir;
    logic [0:0]  b_ov;
    logic [7:0]  b_od;
    logic        b_ordy;
    logic        b_fl;
    logic [7:0]  b_st;
    logic [1:0]  b_occ;

    int checks = 0;
    int errors = 0;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    pipe_stage_buf #(.WIDTH(8), .LANES(2), .SKID(1), .EXC_BIT(0), .CNT_W(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_iv),
        .in_data   (a_d),
        .in_ready  (a_ir),
        .out_valid (a_ov),
        .out_data  (a_od),
        .out_ready (a_ordy),
        .flush     (a_fl),
        .stall_cnt (a_st),
        .occupancy (a_occ)
    );

    pipe_stage_buf #(.WIDTH(8), .LANES(1), .SKID(0), .EXC_BIT(0), .CNT_W(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_iv),
        .in_data   (b_d),
        .in_ready  (b_ir),
        .out_valid (b_ov),
        .out_data  (b_od),
        .out_ready (b_ordy),
        .flush     (b_fl),
        .stall_cnt (b_st),
        .occupancy (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [1:0] iv, input logic [15:0] d,
                                input logic ordy, input logic fl,
                                input logic [1:0] ov, input logic [15:0] od,
                                input logic ir, input logic [1:0] occ,
                                input logic [7:0] st);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.st = st;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit sel_b);
        if (sel_b) begin
            b_iv = v.iv[0:0]; b_d = v.d[7:0]; b_ordy = v.ordy; b_fl = v.fl;
        end else begin
            a_iv = v.iv; a_d = v.d; a_ordy = v.ordy; a_fl = v.fl;
        end
    endtask

    task automatic checkVector(input vec_t v, input int idx, input bit sel_b);
        string p;
        p = $sformatf("%s_row%0d", sel_b ? "b" : "a", idx);
        if (sel_b) begin
            checkOutput({p, "_out_valid"}, 32'(b_ov), 32'(v.ov[0:0]));
            if (v.ov != 2'b00) checkOutput({p, "_out_data"}, 32'(b_od), 32'(v.od[7:0]));
            checkOutput({p, "_in_ready"}, 32'(b_ir), 32'(v.ir));
            checkOutput({p, "_occupancy"}, 32'(b_occ), 32'(v.occ));
            checkOutput({p, "_stall_cnt"}, 32'(b_st), 32'(v.st));
        end else begin
            checkOutput({p, "_out_valid"}, 32'(a_ov), 32'(v.ov));
            if (v.ov != 2'b00) checkOutput({p, "_out_data"}, 32'(a_od), 32'(v.od));
            checkOutput({p, "_in_ready"}, 32'(a_ir), 32'(v.ir));
            checkOutput({p, "_occupancy"}, 32'(a_occ), 32'(v.occ));
            checkOutput({p, "_stall_cnt"}, 32'(a_st), 32'(v.st[3:0]));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 iv     d        ordy  fl    ov     od       ir    occ   st
        // pass-through, one group per cycle
        tbl_a.push_back(mk(2'b01, 16'h000A, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd0));
        tbl_a.push_back(mk(2'b01, 16'h000B, 1'b1, 1'b0, 2'b01, 16'h000A, 1'b1, 2'd1, 8'd0));
        tbl_a.push_back(mk(2'b01, 16'h000C, 1'b1, 1'b0, 2'b01, 16'h000B, 1'b1, 2'd1, 8'd0));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b01, 16'h000C, 1'b1, 2'd1, 8'd0));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd0));
        // back-pressure into skid, then drain in order
        tbl_a.push_back(mk(2'b01, 16'h0011, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd0));
        tbl_a.push_back(mk(2'b01, 16'h0022, 1'b0, 1'b0, 2'b01, 16'h0011, 1'b1, 2'd1, 8'd0));
        tbl_a.push_back(mk(2'b01, 16'h0033, 1'b0, 1'b0, 2'b01, 16'h0011, 1'b0, 2'd2, 8'd1));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b0, 1'b0, 2'b01, 16'h0011, 1'b0, 2'd2, 8'd2));
        tbl_a.push_back(mk(2'b01, 16'h0033, 1'b1, 1'b0, 2'b01, 16'h0011, 1'b0, 2'd2, 8'd3));
        tbl_a.push_back(mk(2'b01, 16'h0033, 1'b1, 1'b0, 2'b01, 16'h0022, 1'b1, 2'd1, 8'd3));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b01, 16'h0033, 1'b1, 2'd1, 8'd3));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd3));
        // exception kill: lane0 0x01 kills lane1; lane1 exception leaves lane0
        tbl_a.push_back(mk(2'b11, 16'h0401, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd3));
        tbl_a.push_back(mk(2'b11, 16'h0302, 1'b0, 1'b0, 2'b01, 16'h0401, 1'b1, 2'd1, 8'd3));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b01, 16'h0401, 1'b0, 2'd2, 8'd4));
        tbl_a.push_back(mk(2'b10, 16'h0500, 1'b1, 1'b0, 2'b11, 16'h0302, 1'b1, 2'd1, 8'd4));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b10, 16'h0500, 1'b1, 2'd1, 8'd4));
        // exception bit on an invalid lane has no effect
        tbl_a.push_back(mk(2'b10, 16'h0201, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd4));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b10, 16'h0201, 1'b1, 2'd1, 8'd4));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd4));
        // flush while full with an input group present, then flush with accept
        tbl_a.push_back(mk(2'b01, 16'h0044, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd4));
        tbl_a.push_back(mk(2'b01, 16'h0055, 1'b0, 1'b0, 2'b01, 16'h0044, 1'b1, 2'd1, 8'd4));
        tbl_a.push_back(mk(2'b01, 16'h0066, 1'b0, 1'b1, 2'b01, 16'h0044, 1'b0, 2'd2, 8'd5));
        tbl_a.push_back(mk(2'b01, 16'h0077, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd6));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd6));
        // flush together with a retiring head
        tbl_a.push_back(mk(2'b01, 16'h0088, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd6));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b1, 2'b01, 16'h0088, 1'b1, 2'd1, 8'd6));
        tbl_a.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd6));

        // no-skid buffer: ready drops with out_ready, nothing lost
        tbl_b.push_back(mk(2'b01, 16'h0010, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd0));
        tbl_b.push_back(mk(2'b01, 16'h0020, 1'b0, 1'b0, 2'b01, 16'h0010, 1'b0, 2'd1, 8'd0));
        tbl_b.push_back(mk(2'b01, 16'h0020, 1'b1, 1'b0, 2'b01, 16'h0010, 1'b1, 2'd1, 8'd1));
        tbl_b.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b01, 16'h0020, 1'b1, 2'd1, 8'd1));
        tbl_b.push_back(mk(2'b01, 16'h0030, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd1));
        tbl_b.push_back(mk(2'b01, 16'h0040, 1'b1, 1'b1, 2'b01, 16'h0030, 1'b1, 2'd1, 8'd1));
        tbl_b.push_back(mk(2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0, 8'd1));

        rst = 1'b1;
        a_iv = '0; a_d = '0; a_ordy = 1'b0; a_fl = 1'b0;
        b_iv = '0; b_d = '0; b_ordy = 1'b0; b_fl = 1'b0;

        // reset state of both instances
        nextCycle();
        @(negedge clk);
        checkOutput("a_reset_in_ready", 32'(a_ir), 32'd0);
        checkOutput("a_reset_out_valid", 32'(a_ov), 32'd0);
        checkOutput("a_reset_out_data", 32'(a_od), 32'd0);
        checkOutput("a_reset_occupancy", 32'(a_occ), 32'd0);
        checkOutput("a_reset_stall_cnt", 32'(a_st), 32'd0);
        checkOutput("b_reset_in_ready", 32'(b_ir), 32'd0);
        checkOutput("b_reset_out_valid", 32'(b_ov), 32'd0);
        nextCycle();
        rst = 1'b0;

        foreach (tbl_a[i]) begin
            applyStimulus(tbl_a[i], 1'b0);
            @(negedge clk);
            checkVector(tbl_a[i], i, 1'b0);
            nextCycle();
        end

        // stall counter saturation: 6 already counted, 20 more stall cycles
        a_iv = 2'b01; a_d = 16'h0099; a_ordy = 1'b0; a_fl = 1'b0;
        @(negedge clk);
        checkOutput("sat_load_in_ready", 32'(a_ir), 32'd1);
        nextCycle();
        a_iv = 2'b00; a_d = 16'h0000;
        repeat (20) nextCycle();
        @(negedge clk);
        checkOutput("sat_stall_cnt", 32'(a_st), 32'd15);
        checkOutput("sat_out_valid", 32'(a_ov), 32'd1);
        checkOutput("sat_out_data", 32'(a_od), 32'h99);
        checkOutput("sat_occupancy", 32'(a_occ), 32'd1);

        // reset mid-stream: ready low during reset, all state cleared at edge
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready_low", 32'(a_ir), 32'd0);
        checkOutput("midrst_pre_edge_valid", 32'(a_ov), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(a_ov), 32'd0);
        checkOutput("midrst_out_data", 32'(a_od), 32'd0);
        checkOutput("midrst_occupancy", 32'(a_occ), 32'd0);
        checkOutput("midrst_stall_cnt", 32'(a_st), 32'd0);
        checkOutput("midrst_in_ready_held", 32'(a_ir), 32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_in_ready", 32'(a_ir), 32'd1);
        nextCycle();

        foreach (tbl_b[i]) begin
            applyStimulus(tbl_b[i], 1'b1);
            @(negedge clk);
            checkVector(tbl_b[i], i, 1'b1);
            nextCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register that carries an N-lane instruction group between pipeline stages. It adds a valid/ready handshake, an optional skid entry for registered back-pressure, synchronous flush, and younger-lane kill on exception. It generalises the fixed per-stage bundles (IF/ID, ID/EXE, EXE/MEM, MEM/WB) so that every stage boundary, including a future dual-issue front end, instantiates one block. It also keeps a saturating stall counter for performance analysis.

## Interface
Parameters:
- WIDTH, 32: payload bits per lane.
- LANES, 1: lanes per group (1..4). Lane 0 is the oldest.
- SKID, 1: 1 gives a 2-entry buffer with registered in_ready; 0 gives a single register with combinational ready.
- EXC_BIT, 0: bit index within each lane payload that flags an exception.
- CNT_W, 16: stall counter width.

Ports (clock and reset first):
- clk  in  1  stage clock. One clock domain only.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  LANES  per-lane valid from the upstream stage.
- in_data  in  LANES*WIDTH  lane payloads. Lane i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  1  group-level accept.
- out_valid  out  LANES  per-lane valid toward the downstream stage.
- out_data  out  LANES*WIDTH  head group payloads.
- out_ready  in  1  downstream accepts the head group.
- flush  in  1  discard all held and incoming groups.
- stall_cnt  out  CNT_W  cycles in which out_valid != 0 and out_ready = 0. Saturates at all-ones.
- occupancy  out  2  number of groups held (0..2).

## Operation
- A group is present when any in_valid bit is set. Accept happens when the group is present and in_ready is high.
- A group retires when any out_valid bit is set and out_ready is high.
- Groups move as a unit. Lanes are never split across cycles.
- Exception kill on capture: if lane i of an accepted group has in_data[i*WIDTH+EXC_BIT] = 1 and in_valid[i] = 1, then the captured valid bits for all lanes j > i are cleared. Their data is still stored.
- SKID=1 buffer:
  - Entries are head and skid.
  - in_ready = !skid_valid, driven from a register.
  - When the head is stalled and a group is accepted, the group goes to skid.
  - When the head retires, skid moves to head in the same edge.
  - If the head retires while a group is accepted and skid is empty, the new group goes directly to head.
- SKID=0 buffer: in_ready = !head_valid || out_ready. occupancy never exceeds 1.
- Ordering is strict FIFO.
- Flush:
  - Highest priority. On the next edge all valid bits are cleared and occupancy becomes 0.
  - A group accepted in the flush cycle is dropped.
  - The head is not presented as retired.
  - stall_cnt is unaffected by flush.
- stall_cnt:
  - Increments in each cycle with a valid head and out_ready = 0.
  - Holds at 2^CNT_W − 1 once saturated.
  - Cleared only by rst.
- Simultaneous events:
  - With SKID=1 and occupancy 2, retire plus accept is impossible because in_ready = 0.
  - With occupancy 1, retire plus accept keeps occupancy at 1.
  - Flush plus out_ready in the same cycle: the head still handshakes on the out port that cycle, then the buffer empties.

## Timing
- Latency: accept at edge k gives out_valid from cycle k+1.
- Throughput is one group per cycle when out_ready stays high.
- SKID=1: in_ready has no combinational path from out_ready.
- SKID=0: there is a combinational out_ready → in_ready path.
- Reset values: out_valid = 0, out_data = 0, occupancy = 0, stall_cnt = 0.
- in_ready is 0 while rst is high. It becomes 1 on the first cycle after rst falls.
- Reset mid-operation discards all groups at the reset edge, with the same effect as flush, and also clears stall_cnt.
- Payload registers are reset only so that out_data is deterministic. Downstream logic must qualify out_data with out_valid.

## Structure
- Package pipe_pkg holds:
  - the localparam for the maximum lane count;
  - the typedef for the per-lane control bundle (valid plus exception flag);
  - a function kill_younger(valid, exc) returning the masked valid vector.
- Sub-module pipe_slot implements one entry: register plus valid, with load/clear. Instantiate it twice for SKID=1 and once for SKID=0.
- The top level contains the head/skid steering FSM, with states EMPTY, ONE and FULL, plus the counter.

## Test plan
- Basic pass-through: LANES=1, SKID=1, out_ready=1. Drive data 0xA, 0xB, 0xC on consecutive cycles. out_data must show 0xA, 0xB, 0xC one cycle later with no bubble, and occupancy must stay at 1.
- Back-pressure: hold out_ready=0 for 3 cycles with two groups sent. Required: occupancy=2, in_ready=0, stall_cnt=3. Then raise out_ready: the groups drain in order and in_ready rises one cycle after the first retire.
- Exception kill: LANES=2, EXC_BIT=0. Send lane0 data 0x1 (exception) and lane1 data 0x4, both valid. Required: out_valid=2'b01.
- Flush: flush with occupancy=2 and a simultaneous input group. Required: next cycle out_valid=0, occupancy=0, in_ready=1.
- SKID=0: set out_ready=0 for one cycle. in_ready must drop in the same cycle, occupancy stays ≤1, and no data is lost.
- Counter and reset: with CNT_W=4, hold the stall for 20 cycles. stall_cnt must read 15. Assert rst mid-stream: all outputs return to their reset values.
